bus_arbiter2: RTL and testbench

//  Round-robin arbiter sharing one WIDTH-bit datapath bus between two requesters.

---
 rtl/bus_arbiter2.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter2.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2.sv
// bus_arbiter2: round-robin arbiter sharing one WIDTH-bit datapath bus
// between two requesters, with bounded tenure.
//
// Drives the select of the downstream combinational 2:1 data mux
// (S1: 0 = D1, 1 = D2) and registers the selected word onto O.
//
// Ports:
//   CLK     in   1      system clock, rising edge
//   Reset   in   1      synchronous, active-high reset
//   REQ1    in   1      requester 1 wants the bus, held for the whole transfer
//   REQ2    in   1      requester 2 wants the bus
//   D1      in   WIDTH  requester 1 data, valid while GNT1 & REQ1
//   D2      in   WIDTH  requester 2 data, valid while GNT2 & REQ2
//   GNT1    out  1      registered grant to requester 1
//   GNT2    out  1      registered grant to requester 2
//   S1      out  1      mux select; holds its last value while idle
//   O       out  WIDTH  registered captured word
//   OValid  out  1      one-cycle pulse per captured word
//   Busy    out  1      GNT1 | GNT2
module bus_arbiter2 #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             REQ1,
  input  logic             REQ2,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic             GNT1,
  output logic             GNT2,
  output logic             S1,
  output logic [WIDTH-1:0] O,
  output logic             OValid,
  output logic             Busy
);

  localparam int unsigned    CW      = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, G1, G2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  // 1 when requester 2 held the most recent tenure; ties go to the other side.
  logic          last2;
  logic [CW-1:0] cnt_inc;

  // Word count for the current tenure, saturating at MAX_HOLD.
  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  end

  always_comb begin
    Busy = GNT1 | GNT2;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      GNT1   <= 1'b0;
      GNT2   <= 1'b0;
      S1     <= 1'b0;
      O      <= '0;
      OValid <= 1'b0;
      cnt    <= '0;
      last2  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          OValid <= 1'b0;
          if (REQ1 && (!REQ2 || last2)) begin
            state <= G1;
            GNT1  <= 1'b1;
            GNT2  <= 1'b0;
            S1    <= 1'b0;
            cnt   <= '0;
            last2 <= 1'b0;
          end else if (REQ2) begin
            state <= G2;
            GNT1  <= 1'b0;
            GNT2  <= 1'b1;
            S1    <= 1'b1;
            cnt   <= '0;
            last2 <= 1'b1;
          end
        end

        G1: begin
          if (REQ1) begin
            O      <= D1;
            OValid <= 1'b1;
            // Preempt only when this capture fills the tenure and the other side waits.
            if ((cnt_inc == CNT_MAX) && REQ2) begin
              state <= G2;
              GNT1  <= 1'b0;
              GNT2  <= 1'b1;
              S1    <= 1'b1;
              cnt   <= '0;
              last2 <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            OValid <= 1'b0;
            if (REQ2) begin
              state <= G2;
              GNT1  <= 1'b0;
              GNT2  <= 1'b1;
              S1    <= 1'b1;
              cnt   <= '0;
              last2 <= 1'b1;
            end else begin
              state <= IDLE;
              GNT1  <= 1'b0;
              GNT2  <= 1'b0;
            end
          end
        end

        G2: begin
          if (REQ2) begin
            O      <= D2;
            OValid <= 1'b1;
            if ((cnt_inc == CNT_MAX) && REQ1) begin
              state <= G1;
              GNT1  <= 1'b1;
              GNT2  <= 1'b0;
              S1    <= 1'b0;
              cnt   <= '0;
              last2 <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            OValid <= 1'b0;
            if (REQ1) begin
              state <= G1;
              GNT1  <= 1'b1;
              GNT2  <= 1'b0;
              S1    <= 1'b0;
              cnt   <= '0;
              last2 <= 1'b0;
            end else begin
              state <= IDLE;
              GNT1  <= 1'b0;
              GNT2  <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          GNT1   <= 1'b0;
          GNT2   <= 1'b0;
          OValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2: directed-vector bench for bus_arbiter2 (WIDTH=16, MAX_HOLD=4).
// Stimulus drives one clock per vector and checks grant/select/valid flags;
// expected captured words go into a queue that a separate monitor drains
// whenever OValid is seen.
module tb_bus_arbiter2;

  logic        CLK;
  logic        Reset;
  logic        REQ1;
  logic        REQ2;
  logic [15:0] D1;
  logic [15:0] D2;
  logic        GNT1;
  logic        GNT2;
  logic        S1;
  logic [15:0] O;
  logic        OValid;
  logic        Busy;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [15:0] exp_q[$];

  bus_arbiter2 #(.WIDTH(16), .MAX_HOLD(4)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .REQ1   (REQ1),
    .REQ2   (REQ2),
    .D1     (D1),
    .D2     (D2),
    .GNT1   (GNT1),
    .GNT2   (GNT2),
    .S1     (S1),
    .O      (O),
    .OValid (OValid),
    .Busy   (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Data monitor: every OValid pulse must match the oldest expected word.
  always @(negedge CLK) begin
    if (OValid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL data_unexpected: got O=%0d with OValid, expected no word", O);
      end else begin
        logic [15:0] w;
        w = exp_q.pop_front();
        if (O !== w) begin
          n_fail++;
          $display("FAIL data_word: got O=%0d, expected %0d", O, w);
        end
      end
    end
  end

  // One clock: drive inputs, optionally queue the word this edge should
  // capture, then check {GNT1,GNT2,S1,Busy,OValid} just after the edge.
  task automatic cyc(input logic rst, input logic r1, input logic r2,
                     input logic [15:0] d1, input logic [15:0] d2,
                     input logic eg1, input logic eg2, input logic es1,
                     input logic ev, input logic [15:0] ew);
    logic [4:0] got;
    logic [4:0] exp;
    Reset = rst;
    REQ1  = r1;
    REQ2  = r2;
    D1    = d1;
    D2    = d2;
    if (ev) exp_q.push_back(ew);
    @(posedge CLK);
    #1;
    got = {GNT1, GNT2, S1, Busy, OValid};
    exp = {eg1, eg2, es1, eg1 | eg2, ev};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flags at %0t: got {GNT1,GNT2,S1,Busy,OValid}=%b, expected %b",
               $time, got, exp);
    end
  endtask

  task automatic check_o_zero(input string name);
    n_checks++;
    if (O !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: got O=%0d, expected 0", name, O);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b1; REQ1 = 1'b0; REQ2 = 1'b0; D1 = '0; D2 = '0;

    // Reset with both requests high.
    cyc(1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
    check_o_zero("reset_o");

    // Single requester 1.
    cyc(0, 1, 0, 77, 0,  1, 0, 0, 0, 0);
    cyc(0, 1, 0, 77, 0,  1, 0, 0, 1, 77);
    cyc(0, 1, 0, 77, 0,  1, 0, 0, 1, 77);
    cyc(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    // Tie after reset: requester 1 first, then hand-over on REQ1 drop.
    cyc(0, 1, 1, 77, 99, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 77, 99, 1, 0, 0, 1, 77);
    cyc(0, 0, 1, 0, 99,  0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 99,  0, 1, 1, 1, 99);
    cyc(0, 0, 0, 0, 0,   0, 0, 1, 0, 0);   // idle keeps S1

    // Ties alternate with the last holder.
    cyc(0, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0,   0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 5,   0, 1, 1, 1, 5);
    cyc(0, 1, 0, 0, 0,   1, 0, 0, 0, 0);

    // Preemption after MAX_HOLD words while requester 2 waits.
    for (int unsigned i = 1; i <= 3; i++)
      cyc(0, 1, 1, 16'(i), 0, 1, 0, 0, 1, 16'(i));
    cyc(0, 1, 1, 4, 0,   0, 1, 1, 1, 4);
    cyc(0, 1, 1, 5, 99,  0, 1, 1, 1, 99);
    cyc(0, 1, 0, 6, 0,   1, 0, 0, 0, 0);
    // Alone past MAX_HOLD: keeps capturing, no switch.
    for (int unsigned i = 7; i <= 11; i++)
      cyc(0, 1, 0, 16'(i), 0, 1, 0, 0, 1, 16'(i));
    cyc(0, 0, 1, 0, 0,   0, 1, 1, 0, 0);

    // Reset in the middle of a G2 tenure.
    cyc(0, 0, 1, 0, 99,  0, 1, 1, 1, 99);
    cyc(1, 1, 1, 0, 0,   0, 0, 0, 0, 0);
    check_o_zero("midreset_o");
    cyc(0, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    @(negedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL data_pending: got %0d words never presented, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
